// File: rtl/ads_serial_capture_if.sv
// ADC-facing serial bus and result bus of ads_serial_capture.
// The capture block owns everything except the SDO lines, which the ADC drives.
interface ads_serial_capture_if #(
   parameter int N_CH   = 2,
   parameter int DATA_W = 12
);
   logic                   oSDI;
   logic                   oCS_n;
   logic                   oCLK;
   logic [N_CH-1:0]        iSDO;
   logic [N_CH*DATA_W-1:0] odata;
   logic                   odata_valid;
   logic                   obusy;
   logic                   ooverrun;

   modport master (
      output oSDI, oCS_n, oCLK, odata, odata_valid, obusy, ooverrun,
      input  iSDO
   );

   modport slave (
      input  oSDI, oCS_n, oCLK, odata, odata_valid, obusy, ooverrun,
      output iSDO
   );
endinterface

// File: rtl/ads_serial_capture.sv
// SPI-style SAR ADC frame engine.
// Generates CS_n and SCLK, shifts out a fixed command word, and captures N_CH
// SDO lines in parallel. Frames start on a synchronised iSYNC edge or run
// back-to-back in free-run mode.
module ads_serial_capture #(
   parameter int                    N_CH       = 2,
   parameter int                    DATA_W     = 12,
   parameter int                    FRAME_BITS = 32,
   parameter int                    LEAD_BITS  = 2,
   parameter int                    CLK_DIV    = 2,
   parameter int                    CS_HIGH    = 4,
   parameter int                    SYNC_EDGE  = 0,
   parameter logic [FRAME_BITS-1:0] SDI_WORD   = '0
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iSYNC,
   input  logic                  iFREE_RUN,
   ads_serial_capture_if.master  bus
);

   localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HIGH - 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] FIRST_KEEP = BIT_W'(LEAD_BITS);
   localparam logic [BIT_W-1:0] LAST_KEEP  = BIT_W'(LEAD_BITS + DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } state_e;

   typedef logic [N_CH-1:0][DATA_W-1:0] words_t;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic              cs_n_q, cs_n_d;
   logic              clk_q, clk_d;
   logic              sdi_q, sdi_d;
   words_t            sh_q, sh_d;
   words_t            data_q, data_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;

   logic              sync1_q, sync2_q, hist_q;
   logic              trigger;

   // Two-flop synchroniser for iSYNC plus one history flop for edge detection.
   always_ff @(posedge iCLK) begin
      // NOTE: clocked state always uses non-blocking (<=) so every flop samples
      // the pre-edge values of the others, exactly like the hardware.
      if (iRST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= iSYNC;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   // History resets to 0, so a level already high at reset release fires once.
   assign trigger = (SYNC_EDGE != 0) ? (sync2_q ^ hist_q) : (sync2_q & ~hist_q);

   // Frame state register and all registered outputs.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         cs_n_q    <= 1'b1;
         clk_q     <= 1'b1;
         sdi_q     <= 1'b0;
         sh_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         cs_n_q    <= cs_n_d;
         clk_q     <= clk_d;
         sdi_q     <= sdi_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
      end
   end

   // Next-state and output decode; in SHIFT the SCLK level itself marks the phase.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      cs_n_d    = cs_n_q;
      clk_d     = clk_q;
      sdi_d     = sdi_q;
      sh_d      = sh_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      busy_d    = busy_q;
      overrun_d = overrun_q | (trigger & (state_q != IDLE) & ~iFREE_RUN);

      unique case (state_q)
         IDLE: begin
            if (trigger || iFREE_RUN) begin
               state_d = SETUP;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               clk_d   = 1'b1;
               cnt_d   = DIV_LOAD;
            end
         end

         SETUP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = SHIFT;
               clk_d   = 1'b0;
               bit_d   = '0;
               sdi_d   = SDI_WORD[LAST_BIT];
               cnt_d   = DIV_LOAD;
            end
         end

         SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!clk_q) begin
               // End of low phase: raise SCLK and sample SDO.
               clk_d = 1'b1;
               cnt_d = DIV_LOAD;
               if ((bit_q >= FIRST_KEEP) && (bit_q <= LAST_KEEP)) begin
                  for (int k = 0; k < N_CH; k++) begin
                     sh_d[k] = (sh_q[k] << 1) | DATA_W'(bus.iSDO[k]);
                  end
               end
            end else if (bit_q == LAST_BIT) begin
               // End of the last high phase: close the frame.
               state_d = HOLD;
               cs_n_d  = 1'b1;
               sdi_d   = 1'b0;
               data_d  = sh_q;
               valid_d = 1'b1;
               cnt_d   = HOLD_LOAD;
            end else begin
               // End of a high phase: start the next bit.
               bit_d = bit_q + BIT_W'(1);
               clk_d = 1'b0;
               sdi_d = SDI_WORD[LAST_BIT - (bit_q + BIT_W'(1))];
               cnt_d = DIV_LOAD;
            end
         end

         HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (iFREE_RUN) begin
               // Re-enter directly so CS_n stays high exactly CS_HIGH cycles.
               state_d = SETUP;
               cs_n_d  = 1'b0;
               clk_d   = 1'b1;
               cnt_d   = DIV_LOAD;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.oSDI        = sdi_q;
   assign bus.oCS_n       = cs_n_q;
   assign bus.oCLK        = clk_q;
   assign bus.odata       = data_q;
   assign bus.odata_valid = valid_q;
   assign bus.obusy       = busy_q;
   assign bus.ooverrun    = overrun_q;

endmodule

// File: tb/tb_ads_serial_capture.sv
// Bench for ads_serial_capture: ADC behavioural model, frame monitor and
// directed/random trigger sequences. DUT a uses rising-edge triggers and a
// marker SDI word; DUT b uses both-edge triggers.
module tb_ads_serial_capture;

   localparam int N_CH       = 2;
   localparam int DATA_W     = 12;
   localparam int FRAME_BITS = 32;
   localparam int LEAD_BITS  = 2;
   localparam int CLK_DIV    = 2;
   localparam int CS_HIGH    = 4;
   localparam logic [31:0] SDI_A = 32'h8000_0001;
   localparam int FRAME_LOW  = CLK_DIV * (1 + 2 * FRAME_BITS);
   localparam int PERIOD     = FRAME_LOW + CS_HIGH;

   typedef logic [N_CH-1:0][DATA_W-1:0] words_t;

   logic iCLK = 1'b0;
   logic iRST = 1'b1;
   logic sync_a = 1'b0;
   logic sync_b = 1'b0;
   logic free_run = 1'b0;

   ads_serial_capture_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus_a ();
   ads_serial_capture_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus_b ();

   ads_serial_capture #(
      .N_CH(N_CH), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS), .LEAD_BITS(LEAD_BITS),
      .CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH), .SYNC_EDGE(0), .SDI_WORD(SDI_A)
   ) dut_a (
      .iCLK(iCLK), .iRST(iRST), .iSYNC(sync_a), .iFREE_RUN(free_run), .bus(bus_a)
   );

   ads_serial_capture #(
      .N_CH(N_CH), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS), .LEAD_BITS(LEAD_BITS),
      .CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH), .SYNC_EDGE(1), .SDI_WORD(32'h0)
   ) dut_b (
      .iCLK(iCLK), .iRST(iRST), .iSYNC(sync_b), .iFREE_RUN(1'b0), .bus(bus_b)
   );

   assign bus_b.iSDO = '1;

   always #5 iCLK = ~iCLK;

   int cyc = 0;
   always @(posedge iCLK) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ADC model: a kept bit MSB first inside the data window, ones elsewhere.
   function automatic logic adc_bit(input logic [DATA_W-1:0] w, input int idx);
      if (idx >= LEAD_BITS && idx < LEAD_BITS + DATA_W)
         return w[DATA_W-1-(idx-LEAD_BITS)];
      return 1'b1;
   endfunction

   function automatic words_t rand_words();
      words_t w;
      for (int k = 0; k < N_CH; k++) w[k] = DATA_W'($urandom);
      return w;
   endfunction

   // Monitor / ADC state
   logic        prev_cs = 1'b1, prev_clk = 1'b1, prev_cs_b = 1'b1;
   bit          in_frame = 1'b0;
   int          low_cnt = 0, rise_cnt = 0, fall_idx = 0, busy_bad = 0;
   int          frames_done = 0, valid_cnt = 0, sdi_idle_bad = 0;
   logic [31:0] sdi_word = '0;
   int          fall_times[$];
   int          fall_b_times[$];
   words_t      cur_words = '0, next_words = '0;

   // Frame monitor and ADC SDO driver, all on the falling iCLK edge.
   always @(negedge iCLK) begin
      if (iRST) begin
         in_frame   = 1'b0;
         bus_a.iSDO = '1;
         prev_cs    = 1'b1;
         prev_clk   = 1'b1;
         prev_cs_b  = 1'b1;
      end else begin
         if (prev_cs && !bus_a.oCS_n) begin
            in_frame  = 1'b1;
            low_cnt   = 0;
            rise_cnt  = 0;
            fall_idx  = 0;
            busy_bad  = 0;
            sdi_word  = '0;
            cur_words = next_words;
            next_words = rand_words();
            fall_times.push_back(cyc);
         end
         if (!bus_a.oCS_n) begin
            low_cnt++;
            if (!bus_a.obusy) busy_bad++;
            if (!prev_clk && bus_a.oCLK) begin
               rise_cnt++;
               sdi_word = {sdi_word[30:0], bus_a.oSDI};
            end
            if (prev_clk && !bus_a.oCLK) begin
               for (int k = 0; k < N_CH; k++) bus_a.iSDO[k] = adc_bit(cur_words[k], fall_idx);
               fall_idx++;
            end
         end else begin
            if (bus_a.oSDI) sdi_idle_bad++;
            if (!prev_cs && in_frame) begin
               check("cs_low_cycles", low_cnt, FRAME_LOW);
               check("sclk_rises", rise_cnt, FRAME_BITS);
               check("sdi_word", sdi_word, SDI_A);
               check("busy_in_frame", busy_bad, 0);
               frames_done++;
               in_frame   = 1'b0;
               bus_a.iSDO = '1;
            end
         end
         if (bus_a.odata_valid) begin
            valid_cnt++;
            check("odata", bus_a.odata, cur_words);
         end
         if (prev_cs_b && !bus_b.oCS_n) fall_b_times.push_back(cyc);
         prev_cs   = bus_a.oCS_n;
         prev_clk  = bus_a.oCLK;
         prev_cs_b = bus_b.oCS_n;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge iCLK);
         #2;
      end
   endtask

   task automatic wait_frames(input int target, input int budget, input string tag);
      int t = 0;
      while (frames_done < target && t < budget) begin
         tick();
         t++;
      end
      check({tag, "_done"}, frames_done >= target, 1);
   endtask

   task automatic wait_falls(input int target, input int budget, input string tag);
      int t = 0;
      while (fall_times.size() < target && t < budget) begin
         tick();
         t++;
      end
      check({tag, "_start"}, fall_times.size() >= target, 1);
   endtask

   function automatic int fall_at(input int i);
      return (fall_times.size() > i) ? fall_times[i] : -1000;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0, n0, fd, vc, t;

      // Reset
      iRST = 1'b1;
      tick(5);
      check("rst_cs_n", bus_a.oCS_n, 1);
      check("rst_sclk", bus_a.oCLK, 1);
      check("rst_sdi", bus_a.oSDI, 0);
      check("rst_odata", bus_a.odata, 0);
      check("rst_valid", bus_a.odata_valid, 0);
      check("rst_busy", bus_a.obusy, 0);
      check("rst_overrun", bus_a.ooverrun, 0);
      check("rst_cs_n_b", bus_b.oCS_n, 1);
      iRST = 1'b0;
      tick(3);
      check("idle_cs_n", bus_a.oCS_n, 1);

      // Single trigger with fixed words
      next_words[0] = 12'hA5C;
      next_words[1] = 12'h3F0;
      t0 = cyc;
      sync_a = 1'b1;
      wait_frames(1, 400, "single");
      check("trig_latency", fall_at(0) - t0, 3);
      check("single_odata", bus_a.odata, 24'h3F0A5C);
      check("single_valids", valid_cnt, 1);
      tick(5);
      check("single_idle_busy", bus_a.obusy, 0);

      // Falling edge must not trigger a rising-only instance
      sync_a = 1'b0;
      tick(20);
      check("fall_no_trigger", fall_times.size(), 1);
      check("no_overrun_yet", bus_a.ooverrun, 0);

      // Both-edge instance: rising then falling edge each start a frame
      t0 = cyc;
      sync_b = 1'b1;
      tick(10);
      check("b_rise_latency", (fall_b_times.size() > 0) ? fall_b_times[0] - t0 : -1, 3);
      tick(200);
      t0 = cyc;
      sync_b = 1'b0;
      tick(10);
      check("b_fall_latency", (fall_b_times.size() > 1) ? fall_b_times[1] - t0 : -1, 3);
      tick(200);
      check("b_frames", fall_b_times.size(), 2);
      check("b_odata", bus_b.odata, 24'hFFFFFF);

      // Overrun: second rising edge about 40 cycles into a frame
      n0 = fall_times.size();
      fd = frames_done;
      sync_a = 1'b1;
      wait_falls(n0 + 1, 20, "ovr");
      tick(28);
      sync_a = 1'b0;
      tick(10);
      sync_a = 1'b1;
      wait_frames(fd + 1, 400, "ovr");
      check("overrun_set", bus_a.ooverrun, 1);
      tick(200);
      check("ovr_no_second_frame", fall_times.size(), n0 + 1);
      check("ovr_frames", frames_done, fd + 1);
      sync_a = 1'b0;
      tick(10);

      // Random triggered frames with random spacing
      for (int i = 0; i < 4; i++) begin
         tick($urandom_range(1, 20));
         n0 = fall_times.size();
         fd = frames_done;
         t0 = cyc;
         sync_a = 1'b1;
         wait_frames(fd + 1, 400, "rand");
         check("rand_latency", fall_at(n0) - t0, 3);
         sync_a = 1'b0;
         tick($urandom_range(5, 15));
      end
      check("overrun_sticky", bus_a.ooverrun, 1);

      // Reset in the middle of a frame around bit 10
      fd = frames_done;
      vc = valid_cnt;
      sync_a = 1'b1;
      t = 0;
      while (!(in_frame && rise_cnt >= 10) && t < 200) begin
         tick();
         t++;
      end
      check("mid_reached_bit10", rise_cnt >= 10, 1);
      iRST = 1'b1;
      tick();
      check("mid_rst_cs_n", bus_a.oCS_n, 1);
      check("mid_rst_sclk", bus_a.oCLK, 1);
      check("mid_rst_valid", bus_a.odata_valid, 0);
      check("mid_rst_odata", bus_a.odata, 0);
      check("mid_rst_overrun", bus_a.ooverrun, 0);
      sync_a = 1'b0;
      tick(2);
      iRST = 1'b0;
      tick(5);
      check("mid_no_valid", valid_cnt, vc);
      check("mid_idle_cs_n", bus_a.oCS_n, 1);
      sync_a = 1'b1;
      wait_frames(fd + 1, 400, "post_rst");
      check("post_rst_valids", valid_cnt, vc + 1);
      sync_a = 1'b0;
      tick(10);

      // Free-run: three back-to-back frames, then drop the mode mid-frame
      n0 = fall_times.size();
      fd = frames_done;
      vc = valid_cnt;
      t0 = cyc;
      free_run = 1'b1;
      wait_falls(n0 + 1, 20, "fr1");
      check("fr_first_latency", fall_at(n0) - t0, 1);
      tick(20);
      sync_a = 1'b1;
      tick(10);
      sync_a = 1'b0;
      wait_falls(n0 + 3, 600, "fr3");
      check("fr_period_1", fall_at(n0 + 1) - fall_at(n0), PERIOD);
      check("fr_period_2", fall_at(n0 + 2) - fall_at(n0 + 1), PERIOD);
      tick(50);
      free_run = 1'b0;
      wait_frames(fd + 3, 400, "fr_end");
      tick(200);
      check("fr_frame_count", fall_times.size(), n0 + 3);
      check("fr_valids", valid_cnt, vc + 3);
      check("fr_idle_cs_n", bus_a.oCS_n, 1);
      check("fr_idle_busy", bus_a.obusy, 0);
      check("fr_no_overrun", bus_a.ooverrun, 0);

      check("sdi_idle_zero", sdi_idle_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
